// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for MEM-stage loads and stores.
// Stalls the pipeline for LATENCY+1 cycles per access, then presents the load data for one DONE cycle.
//
// state | meaning
// IDLE  | no access in flight; a request here is captured and stalls immediately
// WAIT  | latency countdown on the captured request; access happens when the count hits zero
// DONE  | one unstalled cycle so MEM/WB can capture ReadDataM
module dmem_responder #(
    parameter int DEPTH_LOG2 = 9,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        stallM,
    output logic        errM,
    output logic [15:0] rdCount,
    output logic [15:0] wrCount
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    state_t                  nextState;
    logic [3:0]              cnt;
    logic                    capWrite;
    logic [DEPTH_LOG2-1:0]   capIdx;
    logic [31:0]             capData;
    logic                    req;
    logic                    accept;
    logic                    access;
    logic                    badReq;
    logic                    unusedAddrHi;

    logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

    assign req          = MemReadM | MemWriteM;
    assign accept       = (state == IDLE) && req;
    assign access       = (state == WAIT) && (cnt == 4'd0);
    assign badReq       = (MemReadM && MemWriteM) || (ALUOutM[1:0] != 2'b00);
    // High address bits alias onto the array; they are deliberately dropped.
    assign unusedAddrHi = ^ALUOutM[31:DEPTH_LOG2+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        stallM    = 1'b0;
        case (state)
            IDLE: begin
                stallM = req;
                if (req) nextState = WAIT;
            end
            WAIT: begin
                stallM = 1'b1;
                if (cnt == 4'd0) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        // The hazard unit must see no stall while the block is held in reset.
        stallM = stallM & rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            capWrite  <= 1'b0;
            capIdx    <= '0;
            capData   <= 32'd0;
            ReadDataM <= 32'd0;
            errM      <= 1'b0;
            rdCount   <= 16'd0;
            wrCount   <= 16'd0;
        end else begin
            if (accept) begin
                // Read+write together is serviced as a store.
                capWrite <= MemWriteM;
                capIdx   <= ALUOutM[DEPTH_LOG2+1:2];
                capData  <= WriteDataM;
                cnt      <= 4'(LATENCY - 1);
                if (badReq) errM <= 1'b1;
            end else if (state == WAIT) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (capWrite) begin
                    wrCount <= wrCount + 16'd1;
                end else begin
                    ReadDataM <= mem[capIdx];
                    rdCount   <= rdCount + 16'd1;
                end
            end
        end
    end

    // Array is intentionally not reset; state is IDLE during reset so no write can slip through.
    always_ff @(posedge clk) begin
        if (access && capWrite) mem[capIdx] <= capData;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset, store/load, back-to-back, error flags,
// address wrap and reset during a pending store.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [31:0] ReadDataM;
    logic        stallM;
    logic        errM;
    logic [15:0] rdCount;
    logic [15:0] wrCount;

    int total  = 0;
    int passed = 0;

    int          stalls;
    logic [31:0] rdata;
    logic        timedOut;

    dmem_responder #(.DEPTH_LOG2(9), .LATENCY(3)) dut (
        .clk(clk),
        .rst(rst),
        .MemReadM(MemReadM),
        .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM),
        .stallM(stallM),
        .errM(errM),
        .rdCount(rdCount),
        .wrCount(wrCount)
    );

    always #5 clk = ~clk;

    // Called just after a negedge. Drives a request and counts stalled cycles until the
    // DONE cycle is reached; returns in DONE with the inputs still driven.
    // fromDone: the caller is currently in a DONE cycle, so the request is seen next cycle.
    task automatic runReq(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic fromDone,
                          output int nStall, output logic [31:0] dOut, output logic to);
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUOutM    = addr;
        WriteDataM = data;
        nStall     = 0;
        to         = 1'b0;
        if (fromDone) @(negedge clk);
        #1;
        while (stallM === 1'b1 && nStall < 50) begin
            nStall++;
            @(negedge clk);
            #1;
        end
        if (nStall >= 50) to = 1'b1;
        dOut = ReadDataM;
    endtask

    task automatic finishIdle();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'd0;
        WriteDataM = 32'd0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        MemReadM = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (stallM !== 1'b0) $display("FAIL reset_stall_forced: got %b want 0", stallM);
        else passed++;
        MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ReadDataM !== 32'd0) $display("FAIL reset_rdata: got %h want 0", ReadDataM);
        else passed++;
        total++;
        if (stallM !== 1'b0) $display("FAIL reset_stall: got %b want 0", stallM);
        else passed++;
        total++;
        if (errM !== 1'b0) $display("FAIL reset_err: got %b want 0", errM);
        else passed++;
        total++;
        if (rdCount !== 16'd0 || wrCount !== 16'd0)
            $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rdCount, wrCount);
        else passed++;
    endtask

    task automatic test_store_load();
        runReq(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, stalls, rdata, timedOut);
        total++;
        if (timedOut || stalls !== 4) $display("FAIL store_stall: got %0d want 4", stalls);
        else passed++;
        finishIdle();
        total++;
        if (wrCount !== 16'd1) $display("FAIL store_wrcount: got %0d want 1", wrCount);
        else passed++;
        runReq(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, stalls, rdata, timedOut);
        total++;
        if (timedOut || stalls !== 4) $display("FAIL load_stall: got %0d want 4", stalls);
        else passed++;
        total++;
        if (rdata !== 32'hDEADBEEF) $display("FAIL load_data: got %h want deadbeef", rdata);
        else passed++;
        finishIdle();
        total++;
        if (rdCount !== 16'd1) $display("FAIL load_rdcount: got %0d want 1", rdCount);
        else passed++;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ReadDataM !== 32'hDEADBEEF || stallM !== 1'b0)
            $display("FAIL idle_hold: got data=%h stall=%b want deadbeef/0", ReadDataM, stallM);
        else passed++;
    endtask

    task automatic test_back_to_back();
        runReq(1'b0, 1'b1, 32'h14, 32'h0BADF00D, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        runReq(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, stalls, rdata, timedOut);
        total++;
        if (timedOut || stalls !== 4 || rdata !== 32'hDEADBEEF)
            $display("FAIL b2b_first: got stalls=%0d data=%h want 4/deadbeef", stalls, rdata);
        else passed++;
        runReq(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, stalls, rdata, timedOut);
        total++;
        if (timedOut || stalls !== 4 || rdata !== 32'h0BADF00D)
            $display("FAIL b2b_second: got stalls=%0d data=%h want 4/0badf00d", stalls, rdata);
        else passed++;
        finishIdle();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (rdCount !== 16'd3 || wrCount !== 16'd2 || stallM !== 1'b0)
            $display("FAIL b2b_counts: got rd=%0d wr=%0d stall=%b want 3/2/0", rdCount, wrCount, stallM);
        else passed++;
    endtask

    task automatic test_errors();
        runReq(1'b0, 1'b1, 32'h13, 32'h00000077, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        total++;
        if (errM !== 1'b1 || wrCount !== 16'd3)
            $display("FAIL misalign_err: got err=%b wr=%0d want 1/3", errM, wrCount);
        else passed++;
        runReq(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        total++;
        if (rdata !== 32'h00000077) $display("FAIL misalign_word: got %h want 00000077", rdata);
        else passed++;
        runReq(1'b1, 1'b1, 32'h20, 32'h00000005, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        total++;
        if (wrCount !== 16'd4 || rdCount !== 16'd4 || stalls !== 4)
            $display("FAIL rdwr_as_store: got wr=%0d rd=%0d stalls=%0d want 4/4/4", wrCount, rdCount, stalls);
        else passed++;
        runReq(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        total++;
        if (rdata !== 32'h5 || errM !== 1'b1)
            $display("FAIL rdwr_data: got data=%h err=%b want 00000005/1", rdata, errM);
        else passed++;
    endtask

    task automatic test_wrap();
        runReq(1'b0, 1'b1, 32'h00000800, 32'h00001234, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        runReq(1'b1, 1'b0, 32'h00000000, 32'h0, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        total++;
        if (rdata !== 32'h00001234) $display("FAIL wrap_data: got %h want 00001234", rdata);
        else passed++;
        total++;
        if (rdCount !== 16'd6 || wrCount !== 16'd5)
            $display("FAIL wrap_counts: got rd=%0d wr=%0d want 6/5", rdCount, wrCount);
        else passed++;
    endtask

    task automatic test_reset_mid_store();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        runReq(1'b0, 1'b1, 32'h30, 32'h11112222, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        total++;
        if (wrCount !== 16'd1 || errM !== 1'b0)
            $display("FAIL pre_store: got wr=%0d err=%b want 1/0", wrCount, errM);
        else passed++;
        MemWriteM  = 1'b1;
        ALUOutM    = 32'h30;
        WriteDataM = 32'h0000AAAA;
        repeat (2) @(negedge clk);
        #2;
        total++;
        if (stallM !== 1'b1) $display("FAIL mid_waiting: got stall=%b want 1", stallM);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (stallM !== 1'b0 || wrCount !== 16'd0)
            $display("FAIL mid_reset: got stall=%b wr=%0d want 0/0", stallM, wrCount);
        else passed++;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'd0;
        WriteDataM = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        runReq(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, stalls, rdata, timedOut);
        finishIdle();
        total++;
        if (rdata !== 32'h11112222 || wrCount !== 16'd0 || rdCount !== 16'd1)
            $display("FAIL mid_dropped: got data=%h wr=%0d rd=%0d want 11112222/0/1", rdata, wrCount, rdCount);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_wrap();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
